// File: rtl/alu_operand_stage.sv
// Operand-select stage ahead of the ALU: resolves rs1/rs2 through a priority
// forwarding network, muxes operands and holds the bundle in a valid/ready register.
module alu_operand_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           rs1_addr,
   input  logic [4:0]           rs2_addr,
   input  logic [XLEN-1:0]      rs1_val,
   input  logic [XLEN-1:0]      rs2_val,
   input  logic [XLEN-1:0]      pc,
   input  logic [XLEN-1:0]      imm,
   input  logic [1:0]           src_a_sel,
   input  logic [1:0]           src_b_sel,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD*5-1:0]    fwd_rd,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      op_a,
   output logic [XLEN-1:0]      op_b,
   output logic [XLEN-1:0]      store_data,
   output logic                 fwd_hit_a,
   output logic                 fwd_hit_b
);

   localparam int unsigned RW = 5;

   logic [XLEN-1:0] rs1_res_c;
   logic [XLEN-1:0] rs2_res_c;
   logic            rs1_fwd_c;
   logic            rs2_fwd_c;
   logic [XLEN-1:0] op_a_c;
   logic [XLEN-1:0] op_b_c;
   logic            capture_c;

   // Walk from lowest priority up so the lowest matching index wins; x0 never forwards.
   always_comb begin
      rs1_res_c = rs1_val;
      rs2_res_c = rs2_val;
      rs1_fwd_c = 1'b0;
      rs2_fwd_c = 1'b0;
      for (int i = int'(NFWD) - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_rd[RW*i +: RW] != 5'd0)) begin
            if (fwd_rd[RW*i +: RW] == rs1_addr) begin
               rs1_res_c = fwd_data[XLEN*i +: XLEN];
               rs1_fwd_c = 1'b1;
            end
            if (fwd_rd[RW*i +: RW] == rs2_addr) begin
               rs2_res_c = fwd_data[XLEN*i +: XLEN];
               rs2_fwd_c = 1'b1;
            end
         end
      end
      if (rs1_addr == 5'd0) begin
         rs1_res_c = '0;
         rs1_fwd_c = 1'b0;
      end
      if (rs2_addr == 5'd0) begin
         rs2_res_c = '0;
         rs2_fwd_c = 1'b0;
      end
   end

   // Operand source muxes.
   always_comb begin
      op_a_c = '0;
      op_b_c = '0;
      case (src_a_sel)
         2'd0:    op_a_c = rs1_res_c;
         2'd1:    op_a_c = pc;
         default: op_a_c = '0;
      endcase
      case (src_b_sel)
         2'd0:    op_b_c = rs2_res_c;
         2'd1:    op_b_c = imm;
         2'd2:    op_b_c = XLEN'(32'd4);
         default: op_b_c = '0;
      endcase
   end

   assign in_ready  = !out_valid || out_ready;
   assign capture_c = in_valid && in_ready && !flush;

   // Output bundle register; flush beats capture, capture beats drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         store_data <= '0;
         fwd_hit_a  <= 1'b0;
         fwd_hit_b  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture_c) begin
         out_valid  <= 1'b1;
         op_a       <= op_a_c;
         op_b       <= op_b_c;
         store_data <= rs2_res_c;
         fwd_hit_a  <= (src_a_sel == 2'd0) && rs1_fwd_c;
         fwd_hit_b  <= rs2_fwd_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
